// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit feeding the HI/LO inputs of the register-write-data mux.
// Radix-2 Booth multiply and restoring divide, each WIDTH steps followed by one sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Handshake: start_mult/start_div are single-cycle requests honoured only while
  // busy=0; done (or div_zero) pulses for exactly one cycle as the completion response.

  state_t           state;
  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_fits;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Booth add is done one bit wider so the most-negative multiplicand cannot overflow.
  always_comb begin
    booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    case (acc[1:0])
      2'b01:   booth_sum = booth_sum + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = booth_sum - {mcand[WIDTH-1], mcand};
      default: booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    endcase
  end

  // Partial remainder is always below the divisor, so the difference fits in WIDTH bits.
  always_comb begin
    div_shift = {rem, quo[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, mcand});
    div_diff  = div_shift[WIDTH-1:0] - mcand;
    a_mag     = a[WIDTH-1] ? -a : a;
    b_mag     = b[WIDTH-1] ? -b : b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult) begin
            acc    <= {{WIDTH{1'b0}}, b, 1'b0};
            mcand  <= a;
            cnt    <= '0;
            is_div <= 1'b0;
            state  <= MULT;
          end else if (start_div) begin
            if (b == '0) begin
              div_zero <= 1'b1;
            end else begin
              mcand  <= b_mag;
              rem    <= '0;
              quo    <= a_mag;
              neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_r  <= a[WIDTH-1];
              cnt    <= '0;
              is_div <= 1'b1;
              state  <= DIV;
            end
          end
        end
        MULT: begin
          acc <= {booth_sum, acc[WIDTH:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= FIX;
        end
        DIV: begin
          if (div_fits) begin
            rem <= div_diff;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= div_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            lo <= neg_q ? -quo : quo;
            hi <= neg_r ? -rem : rem;
          end else begin
            hi <= acc[2*WIDTH:WIDTH+1];
            lo <= acc[WIDTH:1];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit; its HI and LO registers drive the HI and LO inputs of the register-write-data mux, which are currently tied to zero.
- Operands come from the A and B register outputs. Start pulses and the div-by-zero flag connect to the control unit.
- A div-by-zero event makes the control unit select the DIV_ZERO_EXP vector (255) through the memory-address mux.

Parameters:
WIDTH, 32, operand/HI/LO width; must be even and >= 4.

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
start_mult  in  1  one-cycle request: signed a*b
start_div  in  1  one-cycle request: signed a/b
a  in  WIDTH  operand A (multiplicand/dividend), from register A
b  in  WIDTH  operand B (multiplier/divisor), from register B
hi  out  WIDTH  HI register: product upper half, or remainder
lo  out  WIDTH  LO register: product lower half, or quotient
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse when hi/lo have just been updated
div_zero  out  1  one-cycle pulse when a divide has divisor 0

Behaviour:
- Reset (reset=0, asynchronous):
  - hi=0, lo=0, busy=0, done=0, div_zero=0; state=IDLE; all internal registers cleared.
  - Applies at any time, including mid-operation. The operation in progress is discarded and no done pulse follows.
- States:
  - IDLE, MULT, DIV, FIX.
  - In IDLE, busy=0. In MULT, DIV and FIX, busy=1.
- IDLE:
  - Start inputs are sampled only in IDLE. At edge E with start_mult=1: latch a and b, clear the iteration counter, go to MULT.
  - At edge E with start_div=1 and b!=0: latch the operands, go to DIV.
  - At edge E with start_div=1 and b==0: stay in IDLE, div_zero=1 for exactly the cycle after E, hi/lo unchanged, busy stays 0, done stays 0.
  - If start_mult and start_div are both 1, start_mult wins and start_div is ignored entirely (including any div_zero check).
- MULT:
  - Radix-2 Booth on a 2*WIDTH+1-bit accumulator, one step per cycle, exactly WIDTH cycles (edges E+1..E+WIDTH).
  - Then go to FIX.
- DIV:
  - Restoring division on operand magnitudes, one quotient bit per cycle, exactly WIDTH cycles (edges E+1..E+WIDTH).
  - The sign of the dividend and of the divisor are recorded at E.
  - Then go to FIX.
- FIX (edge E+WIDTH+1):
  - Mult: hi = product[2W-1:W], lo = product[W-1:0].
  - Div: lo = quotient, negated if the operand signs differ (truncation toward zero). hi = remainder, negated if the dividend is negative (remainder takes the dividend's sign).
  - At this edge: done=1 for one cycle, busy=0, state=IDLE.
- Latency: hi/lo are valid, and done is high, in the cycle after edge E+WIDTH+1 (33 edges after the start edge for WIDTH=32).
- A new start may be sampled on the edge immediately after the done cycle begins, i.e. back-to-back operations are allowed.
- Start pulses while busy=1 are ignored and are not queued.
- hi/lo change only at FIX or reset. They hold their values across idle periods and across div-by-zero events.
- Overflow cases (no flag is raised):
  - -2^(W-1) / -1 gives lo=-2^(W-1), hi=0.
  - -2^(W-1) * -2^(W-1) gives the exact 2W-bit product.
- Operand inputs a and b may change after the start edge without affecting the result.
- done and div_zero are never asserted in the same cycle.

Test Plan:
1. start_mult, a=7, b=0xFFFFFFFD (-3) -> busy=1 for 33 cycles; done pulse in the cycle after edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. start_mult, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Then start_mult a=0xFFFFFFFF, b=1 on the first edge of the done cycle -> accepted; next result hi=0xFFFFFFFF, lo=0xFFFFFFFF.
3. start_div, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
4. After test 3, start_div a=5, b=0 -> div_zero=1 for one cycle; busy and done stay 0; hi/lo keep 0x00000001/0xFFFFFFFD. Simultaneous start_mult=1, start_div=1, a=3, b=0 -> no div_zero; multiply runs; hi=0, lo=0.
5. start_div, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, no flag. Pulse start_mult at cycle 5 of the operation -> ignored; result unchanged; single done pulse.
6. start_mult a=123, b=456, assert reset low at cycle 10 -> hi=lo=0 immediately (asynchronous), busy=0; no done pulse after release. New start_div a=100, b=7 -> lo=14, hi=2.
